// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
// ---------------------------------------------------------------------------
// In-order issue controller for the 4-stage register/ALU/writeback/memory
// pipeline. Incoming instruction words are buffered in a small FIFO. The word
// at the FIFO head is checked for read-after-write hazards against the two
// most recently issued instructions. Bubbles are inserted until the producer
// has left the hazard window. Issued fields are presented on registered
// outputs together with a one-cycle strobe.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   instruction word offered on in_instr
//   in_ready   FIFO can accept a word (high when not full)
//   in_instr   [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
//   pause      suppress issue this cycle (bubble instead)
//   flush      synchronous discard of the queue and the hazard history
//   iss_valid  registered one-cycle issue strobe
//   iss_func   issued function code      (held while iss_valid=0)
//   iss_rd     issued destination reg    (held while iss_valid=0)
//   iss_rs1    issued source A           (held while iss_valid=0)
//   iss_rs2    issued source B           (held while iss_valid=0)
//   iss_addr   issued memory address     (held while iss_valid=0)
//   illegal    one-cycle pulse when a func >= 12 word is dropped
//   busy       FIFO non-empty or any history entry valid
//   stall_cnt  cycles lost to hazards, saturating
//   issue_cnt  instructions issued, wrapping
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_instr,
  input  logic             pause,
  input  logic             flush,
  output logic             iss_valid,
  output logic [3:0]       iss_func,
  output logic [3:0]       iss_rd,
  output logic [3:0]       iss_rs1,
  output logic [3:0]       iss_rs2,
  output logic [7:0]       iss_addr,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // FIFO storage and bookkeeping
  logic [23:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  // Hazard history: h0 was issued at the previous edge, h1 two edges ago
  logic       h0_valid;
  logic [3:0] h0_rd;
  logic       h1_valid;
  logic [3:0] h1_rd;

  // Head-of-queue fields
  logic [23:0] head;
  logic [3:0]  head_func;
  logic [3:0]  head_rd;
  logic [3:0]  head_rs1;
  logic [3:0]  head_rs2;
  logic [7:0]  head_addr;

  // Decode and control
  logic head_present;
  logic head_illegal;
  logic reads_rs1;
  logic reads_rs2;
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic active;
  logic drop_now;
  logic issue_now;
  logic stall_now;
  logic push;
  logic pop;

  assign head      = mem[rd_ptr];
  assign head_func = head[23:20];
  assign head_rd   = head[19:16];
  assign head_rs1  = head[15:12];
  assign head_rs2  = head[11:8];
  assign head_addr = head[7:0];

  // Full means no accept, even if the head pops in the same cycle; this
  // keeps in_ready a pure function of occupancy.
  assign in_ready     = (occ != FULL_OCC);
  assign head_present = (occ != '0);
  assign busy         = head_present || h0_valid || h1_valid;

  // Function codes with both top bits set (12 through 15) are illegal.
  assign head_illegal = (head_func[3:2] == 2'b11);

  // Operand usage per function code.
  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    case (head_func)
      4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      4'd3, 4'd8, 4'd10: begin
        reads_rs1 = 1'b1;
      end
      4'd4, 4'd9, 4'd11: begin
        reads_rs2 = 1'b1;
      end
      default: begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
      end
    endcase
  end

  // A source register only counts as a hit if the operand is actually read.
  assign rs1_hit = reads_rs1 &&
                   ((h0_valid && (head_rs1 == h0_rd)) ||
                    (h1_valid && (head_rs1 == h1_rd)));
  assign rs2_hit = reads_rs2 &&
                   ((h0_valid && (head_rs2 == h0_rd)) ||
                    (h1_valid && (head_rs2 == h1_rd)));
  assign hazard  = !head_illegal && (rs1_hit || rs2_hit);

  // Priority at each edge: flush, then illegal drop, then pause, then hazard.
  // Illegal words are dropped even while paused or while a hazard is present.
  assign active    = head_present && !flush;
  assign drop_now  = active && head_illegal;
  assign issue_now = active && !head_illegal && !pause && !hazard;
  assign stall_now = active && !head_illegal && !pause && hazard;
  assign pop       = drop_now || issue_now;
  assign push      = in_valid && in_ready && !flush;

  // FIFO storage is written without reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // FIFO pointers and occupancy; flush returns the queue to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Hazard history shift register. Anything that is not a real issue
  // (bubble, pause, illegal drop, empty queue) shifts in an invalid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_valid <= 1'b0;
      h0_rd    <= '0;
      h1_valid <= 1'b0;
      h1_rd    <= '0;
    end else if (flush) begin
      h0_valid <= 1'b0;
      h1_valid <= 1'b0;
    end else begin
      h1_valid <= h0_valid;
      h1_rd    <= h0_rd;
      h0_valid <= issue_now;
      h0_rd    <= head_rd;
    end
  end

  // Registered issue port. Fields only update on an issue so the pipeline
  // sees stable values during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_func  <= '0;
      iss_rd    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_addr  <= '0;
      illegal   <= 1'b0;
    end else begin
      iss_valid <= issue_now;
      illegal   <= drop_now;
      if (issue_now) begin
        iss_func <= head_func;
        iss_rd   <= head_rd;
        iss_rs1  <= head_rs1;
        iss_rs2  <= head_rs2;
        iss_addr <= head_addr;
      end
    end
  end

  // Performance counters survive a flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall_now && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (issue_now) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for pipe_issue_ctrl. Stimulus pushes each word that is
// expected to issue into a scoreboard together with the hand-computed number
// of cycles since the previous issue/illegal event. A negedge monitor pops
// and compares whenever iss_valid is seen. Directed checks cover counters,
// in_ready, busy, the illegal pulse, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_instr = '0;
  logic        pause = 1'b0;
  logic        flush = 1'b0;
  logic        iss_valid;
  logic [3:0]  iss_func;
  logic [3:0]  iss_rd;
  logic [3:0]  iss_rs1;
  logic [3:0]  iss_rs2;
  logic [7:0]  iss_addr;
  logic        illegal;
  logic        busy;
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;

  pipe_issue_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .pause     (pause),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_func  (iss_func),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_addr  (iss_addr),
    .illegal   (illegal),
    .busy      (busy),
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] instr;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_evt = 0;
  int   ill_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] mk(input int f, input int rd, input int rs1,
                                     input int rs2, input int addr);
    return {f[3:0], rd[3:0], rs1[3:0], rs2[3:0], addr[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Offer one word for exactly one edge; optionally register it as an
  // expected issue with the required gap (-1 means gap not checked).
  task automatic applyStimulus(input logic [23:0] w, input bit exp_issue,
                               input int gap);
    in_valid = 1'b1;
    in_instr = w;
    if (exp_issue) sb.push_back('{instr: w, gap: gap});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every issue against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (illegal) begin
        ill_seen++;
        last_evt = cyc;
      end
      if (iss_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_issue: actual %0h required none",
                   {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr});
        end else begin
          e = sb.pop_front();
          checkOutput("issue_fields",
                      {8'h0, iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr},
                      {8'h0, e.instr});
          if (e.gap >= 0) checkOutput("issue_gap", cyc - last_evt, e.gap);
        end
        last_evt = cyc;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_iss_valid", iss_valid, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_stall", stall_cnt, 0);
    checkOutput("rst_issue", issue_cnt, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    checkOutput("rst_in_ready", in_ready, 1);

    // 1: two independent words back to back
    applyStimulus(mk(0, 1, 2, 3, 8'h11), 1, -1);
    applyStimulus(mk(1, 4, 5, 6, 8'h22), 1, 1);
    idle(4);
    checkOutput("t1_stall", stall_cnt, 0);
    checkOutput("t1_issue", issue_cnt, 2);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_hold", {iss_func, iss_rd}, 8'h14);

    // 2: consumer directly behind producer -> two bubbles
    applyStimulus(mk(0, 1, 2, 3, 8'h33), 1, -1);
    applyStimulus(mk(2, 8, 1, 9, 8'h44), 1, 3);
    idle(6);
    checkOutput("t2_stall", stall_cnt, 2);
    checkOutput("t2_issue", issue_cnt, 4);

    // 3: one independent word between producer and consumer -> one bubble
    applyStimulus(mk(0, 7, 1, 2, 8'h55), 1, -1);
    applyStimulus(mk(0, 10, 11, 12, 8'h66), 1, 1);
    applyStimulus(mk(0, 13, 14, 7, 8'h77), 1, 2);
    idle(6);
    checkOutput("t3_stall", stall_cnt, 3);
    checkOutput("t3_issue", issue_cnt, 7);
    // 3b: func 3 ignores rs2, so rs2=7 is no hazard
    applyStimulus(mk(0, 7, 1, 2, 8'h88), 1, -1);
    applyStimulus(mk(3, 5, 2, 7, 8'h99), 1, 1);
    idle(5);
    checkOutput("t3b_stall", stall_cnt, 3);
    checkOutput("t3b_issue", issue_cnt, 9);

    // 4: fill while paused, fifth offer refused, then drain
    pause = 1'b1;
    applyStimulus(mk(5, 1, 2, 3, 8'h10), 1, -1);
    applyStimulus(mk(6, 4, 5, 6, 8'h20), 1, 1);
    applyStimulus(mk(8, 7, 8, 1, 8'h30), 1, 1);
    applyStimulus(mk(9, 10, 4, 12, 8'h40), 1, 1);
    checkOutput("t4_full_ready", in_ready, 0);
    checkOutput("t4_full_busy", busy, 1);
    applyStimulus(mk(0, 0, 0, 0, 8'hEE), 0, -1);
    checkOutput("t4_still_full", in_ready, 0);
    checkOutput("t4_paused_issue", issue_cnt, 9);
    pause = 1'b0;
    idle(1);
    checkOutput("t4_ready_after_pop", in_ready, 1);
    idle(6);
    checkOutput("t4_issue", issue_cnt, 13);
    checkOutput("t4_stall", stall_cnt, 3);

    // 5: illegal word dropped, legal word follows immediately
    applyStimulus(mk(13, 1, 1, 1, 8'hAA), 0, -1);
    applyStimulus(mk(0, 2, 3, 4, 8'hBB), 1, 1);
    checkOutput("t5_illegal_pulse", illegal, 1);
    checkOutput("t5_no_issue", iss_valid, 0);
    idle(1);
    checkOutput("t5_illegal_end", illegal, 0);
    idle(4);
    checkOutput("t5_issue", issue_cnt, 14);
    checkOutput("t5_ill_seen", ill_seen, 1);
    // 5b: illegal word is dropped even while paused
    pause = 1'b1;
    applyStimulus(mk(14, 3, 3, 3, 8'hCC), 0, -1);
    idle(1);
    checkOutput("t5b_illegal_pause", illegal, 1);
    pause = 1'b0;
    idle(3);
    checkOutput("t5b_ill_seen", ill_seen, 2);
    checkOutput("t5b_busy", busy, 0);

    // 6: flush with three queued words, valid history and a same-cycle push
    pause = 1'b1;
    applyStimulus(mk(0, 3, 1, 2, 8'h01), 1, -1);
    applyStimulus(mk(0, 5, 3, 4, 8'h02), 0, -1);
    applyStimulus(mk(0, 6, 7, 8, 8'h03), 0, -1);
    applyStimulus(mk(0, 9, 10, 11, 8'h04), 0, -1);
    pause = 1'b0;
    idle(1);
    checkOutput("t6_busy_before", busy, 1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(0, 12, 13, 14, 8'h05);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("t6_busy_after", busy, 0);
    checkOutput("t6_iss_valid", iss_valid, 0);
    checkOutput("t6_in_ready", in_ready, 1);
    idle(5);
    checkOutput("t6_issue", issue_cnt, 15);
    checkOutput("t6_stall", stall_cnt, 3);
    checkOutput("t6_busy_idle", busy, 0);

    // 6b: asynchronous reset in mid-stream
    applyStimulus(mk(0, 1, 2, 3, 8'h06), 1, -1);
    applyStimulus(mk(0, 4, 1, 5, 8'h07), 0, -1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_iss_valid", iss_valid, 0);
    checkOutput("ar_fields", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, 0);
    checkOutput("ar_illegal", illegal, 0);
    checkOutput("ar_stall", stall_cnt, 0);
    checkOutput("ar_issue", issue_cnt, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_in_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    idle(5);
    checkOutput("ar_issue_after", issue_cnt, 0);
    checkOutput("ar_busy_after", busy, 0);

    checkOutput("sb_drained", sb.size(), 0);
    checkOutput("ill_total", ill_seen, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
- In-order issue controller for the 4-stage register/ALU/writeback/memory pipeline.
- Buffers incoming instruction words in a small FIFO and detects read-after-write hazards against the two most recently issued instructions.
- Inserts bubbles so that no instruction reads a register before its producer has written it back.
- Drives the pipeline's func/rs1/rs2/rd/addr inputs with a registered, one-cycle issue strobe.

Parameters:
DEPTH, 4, instruction FIFO entries (power of two, >=2)
CNT_W, 16, width of stall and issue counters

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction word offered
in_ready  out  1  FIFO can accept; high when not full
in_instr  in  24  [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
pause  in  1  suppress issue this cycle; bubble issued instead
flush  in  1  synchronous discard of queue and hazard history
iss_valid  out  1  registered issue strobe to pipeline
iss_func  out  4  function code
iss_rd  out  4  destination register
iss_rs1  out  4  source A
iss_rs2  out  4  source B
iss_addr  out  8  memory address
illegal  out  1  one-cycle pulse: func >= 12 dropped
busy  out  1  FIFO non-empty or any history entry valid
stall_cnt  out  CNT_W  cycles lost to hazards, saturating
issue_cnt  out  CNT_W  instructions issued, wrapping

Behaviour:
- Reset (async, rst_n=0): FIFO empty; both history entries invalid.
  - iss_valid=0, iss_*=0, illegal=0, stall_cnt=0, issue_cnt=0.
  - busy=0, in_ready=1 once reset is released.
- Push: in_valid && in_ready && !flush at the rising edge. When full, in_ready=0, even if a pop occurs in the same cycle.
- Operand use by func:
  - func 0,1,2,5,6,7: reads rs1 and rs2.
  - func 3,8,10: reads rs1 only.
  - func 4,9,11: reads rs2 only.
  - func 12-15: illegal.
- History: two entries, H0 (issued at the previous edge) and H1 (issued two edges ago), each holding {valid, rd}.
  - Every edge: H1<=H0; H0<={issued_now, head.rd}.
  - Bubbles, pauses and illegal drops shift in valid=0.
- Hazard: head is legal and any register it reads equals the rd of a valid H0 or H1.
  - Consequence: a dependent instruction issues no earlier than 3 edges after its producer, with 2 bubbles minimum between them.
- Per edge, with the FIFO head present and flush=0:
  - Head illegal: pop; illegal=1 next cycle; iss_valid=0. Checked regardless of pause or hazard.
  - Else if pause: no pop, iss_valid=0.
  - Else if hazard: no pop, iss_valid=0, stall_cnt+1 (saturating at all ones).
  - Else: pop; iss_valid=1 with head fields on iss_*; issue_cnt+1 (wraps).
- Empty FIFO: iss_valid=0 and counters unchanged.
- iss_* fields hold their last issued values while iss_valid=0.
- Latency: word pushed into an empty FIFO with no hazard → iss_valid at the second edge after push (one edge to write, one to issue).
- Flush (sync): FIFO emptied, H0/H1 invalidated, iss_valid=0 and illegal=0 next cycle; counters retained.
  - Flush dominates a same-cycle push and issue.
- Reset mid-operation: everything returns to reset values immediately. Any instruction in the pipeline is abandoned.
- busy is combinational from FIFO count and H0/H1 valid bits.

Test Plan:
1. Push ADD r1=r2+r3, then SUB r4=r5-r6 back-to-back → iss_valid high on 2 consecutive cycles; stall_cnt=0; issue_cnt=2.
2. Push ADD rd=1, then AND reading rs1=1 → ADD issues, 2 idle cycles, AND issues on the 3rd cycle after ADD; stall_cnt=2.
3. Push producer rd=7, independent instruction, consumer rs2=7 → one bubble before consumer; stall_cnt=1.
   - Variant: func=3 reading rs1=2 after producer rd=7 with rs2=7 → no stall.
4. Fill FIFO with 4 words while pause=1 → in_ready=0, a 5th offer is not accepted.
   - Release pause → 4 issues; in_ready returns to 1 after the first pop.
5. Push func=13, then ADD → illegal pulse one cycle, no iss_valid for func=13, ADD issues next cycle; issue_cnt=1.
6. With 3 words queued and history valid, assert flush together with in_valid → FIFO empty, pushed word lost, busy=0 next cycle, counters unchanged.
   - Then pulse rst_n low mid-stream → all outputs zero asynchronously.
